// File: rtl/gmii_tx_arb.sv
// gmii_tx_arb: round-robin arbiter and frame sequencer sharing one GMII
// transmit datapath between PORTS byte-stream sources. Frames are atomic,
// separated by at least IFG idle cycles, and a source that runs dry mid-frame
// produces a tx_er-marked abort while the rest of its frame is discarded.
//
// Handshake: a beat on port i transfers on a rising clk edge where
// s_valid[i] && s_ready[i]; s_ready never depends on s_txd or s_last.
module gmii_tx_arb #(
  parameter int PORTS      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int IFG        = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_txd,
  input  logic [PORTS-1:0]              s_valid,
  input  logic [PORTS-1:0]              s_last,
  output logic [PORTS-1:0]              s_ready,
  output logic [DATA_WIDTH-1:0]         gmii_txd,
  output logic                          gmii_tx_en,
  output logic                          gmii_tx_er,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] grant,
  output logic                          busy,
  output logic                          underflow
);

  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (IFG > 1) ? $clog2(IFG + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

  state_t                state, state_n;
  logic [GW-1:0]         grant_r, grant_n, ptr, ptr_n, pick, grant_inc;
  logic                  found;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  started, started_n;
  logic [DATA_WIDTH-1:0] txd_n;
  logic                  en_n, er_n, uf_n;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;

  // The granted port's stream, selected by the held grant.
  assign g_valid = s_valid[grant_r];
  assign g_last  = s_last[grant_r];
  assign g_data  = s_txd[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin search from the pointer upward with wrap, plus grant+1 mod PORTS.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && s_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
    idx = int'(grant_r) + 1;
    if (idx >= PORTS) idx = 0;
    grant_inc = GW'(idx);
  end

  // Ready: pass-through of valid while transferring, unconditional while dropping.
  always_comb begin
    s_ready = '0;
    if (state == XFER)      s_ready[grant_r] = g_valid;
    else if (state == DROP) s_ready[grant_r] = 1'b1;
  end

  // Next-state and next-output logic; the output register idles at zero.
  always_comb begin
    state_n   = state;
    grant_n   = grant_r;
    ptr_n     = ptr;
    cnt_n     = cnt;
    started_n = started;
    txd_n     = '0;
    en_n      = 1'b0;
    er_n      = 1'b0;
    uf_n      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n   = pick;
          started_n = 1'b0;
          state_n   = XFER;
        end
      end
      XFER: begin
        if (g_valid) begin
          txd_n     = g_data;
          en_n      = 1'b1;
          started_n = 1'b1;
          if (g_last) begin
            ptr_n   = grant_inc;
            cnt_n   = CW'(IFG);
            state_n = GAP;
          end
        end else if (started) begin
          // Source ran dry mid-frame: mark the frame bad and discard the rest.
          en_n    = 1'b1;
          er_n    = 1'b1;
          uf_n    = 1'b1;
          state_n = DROP;
        end
      end
      DROP: begin
        if (g_valid && g_last) begin
          ptr_n   = grant_inc;
          cnt_n   = CW'(IFG);
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt <= CW'(1)) state_n = IDLE;
        else               cnt_n   = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // State, arbitration and registered GMII outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_r    <= '0;
      ptr        <= '0;
      cnt        <= '0;
      started    <= 1'b0;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_n;
      grant_r    <= grant_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      started    <= started_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= en_n;
      gmii_tx_er <= er_n;
      underflow  <= uf_n;
    end
  end

  assign grant = grant_r;
  assign busy  = (state != IDLE);

endmodule
